// File: rtl/pwm_ramp_ctrl_pkg.sv
// pwm_ramp_ctrl_pkg: address map, ramp register offsets, FSM encoding.
// Shared by pwm_ramp_ctrl and pwm_ramp_timer.
package pwm_ramp_ctrl_pkg;

   localparam logic [31:0] DEF_A_BASE    = 32'h6000_0000;
   localparam logic [31:0] DEF_B_BASE    = 32'h6010_0000;
   localparam logic [31:0] DEF_C_ADDR    = 32'h6004_0000;
   localparam logic [31:0] DEF_RAMP_BASE = 32'h6020_0000;

   localparam logic [31:0] RAMP_CTRL_OFS = 32'h0;
   localparam logic [31:0] RAMP_STEP_OFS = 32'h4;
   localparam logic [31:0] RAMP_INTV_OFS = 32'h8;
   localparam logic [31:0] RAMP_LIM_OFS  = 32'hC;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_ISSUE = 2'd2
   } ramp_st_e;

   // Channel stride of 0x1_0000 expressed as a shift.
   function automatic logic [31:0] ch_ofs(input logic [1:0] ch);
      return {14'd0, ch, 16'd0};
   endfunction

   // First enabled channel after ch, wrapping; ch itself if none.
   function automatic logic [1:0] next_ch(input logic [1:0] ch,
                                          input logic [3:0] en);
      logic [1:0] c;
      logic [1:0] r;
      logic       hit;
      r   = ch;
      hit = 1'b0;
      for (int i = 1; i < 4; i++) begin
         c = ch + 2'(i);
         if (!hit && en[c]) begin
            r   = c;
            hit = 1'b1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/pwm_ramp_timer.sv
// pwm_ramp_timer: 32-bit interval counter with tick comparator.
// Ports: clk, rst, en, interval in; tick out (one cycle per period).
module pwm_ramp_timer
   import pwm_ramp_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [31:0] interval,
   output logic        tick
);

   logic [31:0] cnt_q;
   logic [31:0] last;

   // INTERVAL of 0 behaves as 1. A shrunk INTERVAL below the
   // running count fires at once instead of wrapping 2^32.
   always_comb begin
      last = (interval == 32'd0) ? 32'd0 : interval - 32'd1;
      tick = en && (cnt_q >= last);
   end

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         cnt_q <= 32'd0;
      end else if (tick) begin
         cnt_q <= 32'd0;
      end else begin
         cnt_q <= cnt_q + 32'd1;
      end
   end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: forwards CPU PWM writes, ramps B duty registers.
// Ports: clk, rst, cpu_we/addr/data_i; pwm_we/addr/data_o, busy_o.
module pwm_ramp_ctrl
   import pwm_ramp_ctrl_pkg::*;
#(
   parameter logic [31:0] PWM_A_BASE = DEF_A_BASE,
   parameter logic [31:0] PWM_B_BASE = DEF_B_BASE,
   parameter logic [31:0] PWM_C_ADDR = DEF_C_ADDR,
   parameter logic [31:0] RAMP_BASE  = DEF_RAMP_BASE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_we_i,
   input  logic [31:0] cpu_addr_i,
   input  logic [31:0] cpu_data_i,
   output logic        pwm_we_o,
   output logic [31:0] pwm_addr_o,
   output logic [31:0] pwm_data_o,
   output logic        busy_o
);

   logic        in_pwm;
   logic        fwd;
   logic [3:0]  ctrl_q;
   logic [31:0] step_q;
   logic [31:0] intv_q;
   logic [31:0] lim_q;
   logic        active;
   logic        tick;
   logic [1:0]  ch_q;
   logic        ch_en;
   logic [31:0] duty_q [4];
   logic [3:0]  dir_q;
   logic [31:0] duty_cur;
   logic [32:0] sum;
   logic [31:0] duty_nx;
   logic        dir_nx;
   logic        eng_q;
   ramp_st_e    st_q;
   ramp_st_e    st_nx;
   logic        do_upd;
   logic        do_iss;
   logic        do_drop;
   logic        adv;

   // ---- address decode ----
   always_comb begin
      in_pwm = (cpu_addr_i == PWM_C_ADDR);
      for (int i = 0; i < 4; i++) begin
         if (cpu_addr_i == PWM_A_BASE + ch_ofs(2'(i)))
            in_pwm = 1'b1;
         if (cpu_addr_i == PWM_B_BASE + ch_ofs(2'(i)))
            in_pwm = 1'b1;
      end
   end

   assign fwd    = cpu_we_i & in_pwm;
   assign active = |ctrl_q;
   assign ch_en  = ctrl_q[ch_q];

   // ---- ramp registers ----
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q <= 4'd0;
         step_q <= 32'd0;
         intv_q <= 32'd0;
         lim_q  <= 32'd0;
      end else if (cpu_we_i) begin
         unique case (1'b1)
            cpu_addr_i == RAMP_BASE + RAMP_CTRL_OFS:
               ctrl_q <= cpu_data_i[3:0];
            cpu_addr_i == RAMP_BASE + RAMP_STEP_OFS:
               step_q <= cpu_data_i;
            cpu_addr_i == RAMP_BASE + RAMP_INTV_OFS:
               intv_q <= cpu_data_i;
            cpu_addr_i == RAMP_BASE + RAMP_LIM_OFS:
               lim_q  <= cpu_data_i;
            default: ;
         endcase
      end
   end

   pwm_ramp_timer u_timer (
      .clk      (clk),
      .rst      (rst),
      .en       (active),
      .interval (intv_q),
      .tick     (tick)
   );

   // ---- FSM: state register ----
   always_ff @(posedge clk) begin
      if (rst) st_q <= ST_IDLE;
      else     st_q <= st_nx;
   end

   // ---- FSM: next state ----
   always_comb begin
      st_nx = st_q;
      unique case (st_q)
         ST_IDLE: begin
            if (active) st_nx = ST_WAIT;
         end
         ST_WAIT: begin
            if (!active)             st_nx = ST_IDLE;
            else if (ch_en && tick)  st_nx = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (!active)             st_nx = ST_IDLE;
            else if (!ch_en || !fwd) st_nx = ST_WAIT;
         end
         default: st_nx = ST_IDLE;
      endcase
   end

   // ---- FSM: outputs ----
   // do_drop: current channel lost its enable with an update
   // pending, so skip it and move on.
   always_comb begin
      do_upd  = (st_q == ST_WAIT) && active && ch_en && tick;
      do_iss  = (st_q == ST_ISSUE) && active && ch_en && !fwd;
      do_drop = ((st_q == ST_WAIT) || (st_q == ST_ISSUE))
                && active && !ch_en;
      adv     = do_iss || do_drop;
      busy_o  = (st_q == ST_ISSUE) || eng_q;
   end

   // ---- duty step ----
   always_comb begin
      duty_cur = duty_q[ch_q];
      sum      = {1'b0, duty_cur} + {1'b0, step_q};
      duty_nx  = duty_cur;
      dir_nx   = dir_q[ch_q];
      if (!dir_q[ch_q]) begin
         if (sum >= {1'b0, lim_q}) begin
            duty_nx = lim_q;
            dir_nx  = 1'b1;
         end else begin
            duty_nx = sum[31:0];
            dir_nx  = 1'b0;
         end
      end else begin
         if (duty_cur <= step_q) begin
            duty_nx = 32'd0;
            dir_nx  = 1'b0;
         end else begin
            duty_nx = duty_cur - step_q;
            dir_nx  = 1'b1;
         end
      end
   end

   // Disabled channels are held at duty 0, direction up.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) duty_q[i] <= 32'd0;
         dir_q <= 4'd0;
         ch_q  <= 2'd0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (!ctrl_q[i]) begin
               duty_q[i] <= 32'd0;
               dir_q[i]  <= 1'b0;
            end
         end
         if (do_upd) begin
            duty_q[ch_q] <= duty_nx;
            dir_q[ch_q]  <= dir_nx;
         end
         if (adv) ch_q <= next_ch(ch_q, ctrl_q);
      end
   end

   // ---- PWM write port: CPU forward wins over engine ----
   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_we_o   <= 1'b0;
         pwm_addr_o <= 32'd0;
         pwm_data_o <= 32'd0;
         eng_q      <= 1'b0;
      end else if (fwd) begin
         pwm_we_o   <= 1'b1;
         pwm_addr_o <= cpu_addr_i;
         pwm_data_o <= cpu_data_i;
         eng_q      <= 1'b0;
      end else if (do_iss) begin
         pwm_we_o   <= 1'b1;
         pwm_addr_o <= PWM_B_BASE + ch_ofs(ch_q);
         pwm_data_o <= duty_cur;
         eng_q      <= 1'b1;
      end else begin
         pwm_we_o   <= 1'b0;
         pwm_addr_o <= 32'd0;
         pwm_data_o <= 32'd0;
         eng_q      <= 1'b0;
      end
   end

endmodule
